// File: rtl/platform_pkg.sv
// Shared types and constants for the per-scanline platform scheduler.
package platform_pkg;

    localparam int DEF_N_PLATFORMS = 16;
    localparam int DEF_SLOTS       = 4;
    localparam int PLAT_W          = 57;
    localparam int PLAT_H          = 15;
    localparam int FIELD_X0        = 341;
    localparam int FIELD_X1        = 682;

    typedef logic [2:0][3:0] rgb_t;

    typedef struct packed {
        logic       valid;
        logic [8:0] x;
        logic [9:0] y;
    } platform_t;

    typedef struct packed {
        logic       valid;
        logic [8:0] x;
        logic       edge_row;
    } slot_t;

    localparam rgb_t PLAT_RGB      = {4'h4, 4'hB, 4'h2};
    localparam rgb_t PLAT_EDGE_RGB = {4'h1, 4'h6, 4'h0};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // True when a row offset inside a platform is its top or bottom line.
    function automatic logic row_is_edge(input logic [10:0] row_off);
        return (row_off == 11'd0) || (row_off == 11'(PLAT_H - 1));
    endfunction

endpackage

// File: rtl/platform_hit_test.sv
// Combinational test of one active slot against the playfield-relative column.
// on_edge flags the first/last platform column or a slot marked as an edge row.
module platform_hit_test
    import platform_pkg::*;
(
    input  slot_t      slot,
    input  logic [9:0] rel,
    output logic       hit,
    output logic       on_edge
);

    logic [9:0] x_start_s;
    logic [9:0] x_end_s;

    // Column window x <= rel < x + PLAT_W; x is at most 511 so the sum fits 10 bits.
    always_comb begin
        x_start_s = {1'b0, slot.x};
        x_end_s   = x_start_s + 10'(PLAT_W);
        hit       = slot.valid && (rel >= x_start_s) && (rel < x_end_s);
        on_edge   = (rel == x_start_s) || (rel == (x_end_s - 10'd1)) || slot.edge_row;
    end

endmodule

// File: rtl/platform_line_scheduler.sv
// Per-scanline platform scheduler: scans the platform table during hblank,
// double-buffers up to SLOTS hits, and resolves beam_x to a registered colour.
// Optional feature macro: PLATFORM_EDGE_SHADE_EN (edge pixels use PLAT_EDGE_RGB).
module platform_line_scheduler
    import platform_pkg::*;
#(
    parameter int N_PLATFORMS = DEF_N_PLATFORMS,
    parameter int SLOTS       = DEF_SLOTS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           new_line,
    input  logic [9:0]                     next_y,
    input  logic [10:0]                    beam_x,
    input  logic                           draw,
    input  logic                           wr_en,
    input  logic [$clog2(N_PLATFORMS)-1:0] wr_idx,
    input  logic                           wr_valid,
    input  logic [8:0]                     wr_x,
    input  logic [9:0]                     wr_y,
    output logic [2:0][3:0]                platform_colors,
    output logic                           platform_transparencies,
    output logic                           scan_busy,
    output logic                           line_overflow
);

    localparam int IDX_W = $clog2(N_PLATFORMS);
    localparam int CNT_W = $clog2(SLOTS + 1);

    platform_t        table_r [N_PLATFORMS];
    slot_t            shadow_r [SLOTS];
    slot_t            active_r [SLOTS];
    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [CNT_W-1:0] count_r;
    logic [9:0]       next_y_r;

    platform_t        entry_s;
    logic [10:0]      row_off_s;
    logic             scan_hit_s;
    logic             row_edge_s;

    logic             in_field_s;
    logic [9:0]       rel_s;
    logic [SLOTS-1:0] slot_hit_s;
    logic [SLOTS-1:0] slot_edge_s;
    logic             win_hit_s;
    logic             win_edge_s;

    // Table write port; a scan read in the same cycle still sees the old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_PLATFORMS; i++) begin
                table_r[i] <= '0;
            end
        end else if (wr_en) begin
            table_r[wr_idx] <= '{valid: wr_valid, x: wr_x, y: wr_y};
        end
    end

    // Vertical hit test of the entry under scan, in 11 bits so y near 1023 never wraps.
    always_comb begin
        entry_s    = table_r[idx_r];
        row_off_s  = {1'b0, next_y_r} - {1'b0, entry_s.y};
        scan_hit_s = entry_s.valid && ({1'b0, next_y_r} >= {1'b0, entry_s.y})
                     && (row_off_s < 11'(PLAT_H));
`ifdef PLATFORM_EDGE_SHADE_EN
        row_edge_s = row_is_edge(row_off_s);
`else
        row_edge_s = 1'b0;
`endif
    end

    // Scan FSM: a new_line in any state (re)starts the scan; active only changes in COMMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            idx_r         <= '0;
            count_r       <= '0;
            next_y_r      <= 10'd0;
            scan_busy     <= 1'b0;
            line_overflow <= 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                shadow_r[s] <= '0;
                active_r[s] <= '0;
            end
        end else if (new_line) begin
            state_r   <= ST_SCAN;
            idx_r     <= '0;
            count_r   <= '0;
            next_y_r  <= next_y;
            scan_busy <= 1'b1;
            for (int s = 0; s < SLOTS; s++) begin
                shadow_r[s] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    scan_busy <= 1'b0;
                end
                ST_SCAN: begin
                    if (scan_hit_s) begin
                        if (count_r < CNT_W'(SLOTS)) begin
                            for (int s = 0; s < SLOTS; s++) begin
                                if (count_r == CNT_W'(s)) begin
                                    shadow_r[s] <= '{valid: 1'b1, x: entry_s.x, edge_row: row_edge_s};
                                end
                            end
                            count_r <= count_r + CNT_W'(1);
                        end else begin
                            line_overflow <= 1'b1;
                        end
                    end
                    if (idx_r == IDX_W'(N_PLATFORMS - 1)) begin
                        state_r <= ST_COMMIT;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_COMMIT: begin
                    for (int s = 0; s < SLOTS; s++) begin
                        active_r[s] <= shadow_r[s];
                    end
                    state_r   <= ST_IDLE;
                    scan_busy <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

    // Playfield window and playfield-relative column of the beam.
    always_comb begin
        in_field_s = (beam_x >= 11'(FIELD_X0)) && (beam_x < 11'(FIELD_X1));
        rel_s      = 10'(beam_x - 11'(FIELD_X0));
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_hit
        platform_hit_test u_hit (
            .slot    (active_r[g]),
            .rel     (rel_s),
            .hit     (slot_hit_s[g]),
            .on_edge (slot_edge_s[g])
        );
    end

    // Priority select: walking down from the top slot lets the lowest hit overwrite.
    always_comb begin
        win_hit_s  = 1'b0;
        win_edge_s = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_hit_s[i]) begin
                win_hit_s  = 1'b1;
                win_edge_s = slot_edge_s[i];
            end else begin
                win_hit_s  = win_hit_s;
                win_edge_s = win_edge_s;
            end
        end
    end

`ifndef PLATFORM_EDGE_SHADE_EN
    logic unused_win_edge_s;
    assign unused_win_edge_s = win_edge_s;
`endif

    // Registered pixel output, one cycle behind beam_x/draw; out-of-field pixels clip.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            platform_colors         <= '0;
            platform_transparencies <= 1'b1;
        end else if (draw && in_field_s && win_hit_s) begin
            platform_transparencies <= 1'b0;
`ifdef PLATFORM_EDGE_SHADE_EN
            platform_colors <= win_edge_s ? PLAT_EDGE_RGB : PLAT_RGB;
`else
            platform_colors <= PLAT_RGB;
`endif
        end else begin
            platform_colors         <= '0;
            platform_transparencies <= 1'b1;
        end
    end

endmodule

// File: tb/tb_platform_line_scheduler.sv
// Self-checking bench for platform_line_scheduler against a list-based model.
module tb_platform_line_scheduler;

    localparam int NP = 16;
    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            new_line;
    logic [9:0]      next_y;
    logic [10:0]     beam_x;
    logic            draw;
    logic            wr_en;
    logic [3:0]      wr_idx;
    logic            wr_valid;
    logic [8:0]      wr_x;
    logic [9:0]      wr_y;
    logic [2:0][3:0] platform_colors;
    logic            platform_transparencies;
    logic            scan_busy;
    logic            line_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: table, displayed list, pending list, sticky overflow
    bit m_v [NP];
    int m_y [NP];
    int m_x [NP];
    bit a_v [NS];
    int a_x [NS];
    int a_row [NS];
    bit n_v [NS];
    int n_x [NS];
    int n_row [NS];
    bit m_ovf;
    bit pend_ovf;

    platform_line_scheduler dut (
        .clk                     (clk),
        .reset                   (reset),
        .new_line                (new_line),
        .next_y                  (next_y),
        .beam_x                  (beam_x),
        .draw                    (draw),
        .wr_en                   (wr_en),
        .wr_idx                  (wr_idx),
        .wr_valid                (wr_valid),
        .wr_x                    (wr_x),
        .wr_y                    (wr_y),
        .platform_colors         (platform_colors),
        .platform_transparencies (platform_transparencies),
        .scan_busy               (scan_busy),
        .line_overflow           (line_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input bit v, input int x, input int y);
        wr_en    = 1'b1;
        wr_idx   = 4'(i);
        wr_valid = v;
        wr_x     = 9'(x);
        wr_y     = 10'(y);
        tick();
        wr_en    = 1'b0;
        m_v[i]   = v;
        m_x[i]   = x;
        m_y[i]   = y;
    endtask

    // expected pixel from the currently displayed list
    task automatic exp_pix(input int bx, input bit d, output bit tr, output logic [11:0] col);
        int  rel;
        bit  found;
        tr    = 1'b1;
        col   = 12'h000;
        found = 1'b0;
        if (d && bx >= 341 && bx < 682) begin
            rel = bx - 341;
            for (int s = 0; s < NS; s++) begin
                if (!found && a_v[s] && rel >= a_x[s] && rel < a_x[s] + 57) begin
                    found = 1'b1;
                    tr    = 1'b0;
                    col   = 12'h4B2;
`ifdef PLATFORM_EDGE_SHADE_EN
                    if (rel == a_x[s] || rel == a_x[s] + 56 || a_row[s] == 0 || a_row[s] == 14)
                        col = 12'h160;
`endif
                end
            end
        end
    endtask

    task automatic probe(input string tag, input int bx, input bit d);
        bit          etr;
        logic [11:0] ecol;
        beam_x = 11'(bx);
        draw   = d;
        exp_pix(bx, d, etr, ecol);
        tick();
        chk({tag, ".transp"}, 32'(platform_transparencies), 32'(etr));
        chk({tag, ".color"}, 32'(platform_colors), 32'(ecol));
    endtask

    task automatic rand_probe(input string tag);
        int bx;
        if ($urandom_range(0, 1) == 0)
            bx = 341 + a_x[$urandom_range(0, NS - 1)] + int'($urandom_range(0, 60)) - 2;
        else
            bx = int'($urandom_range(320, 700));
        probe(tag, bx, ($urandom_range(0, 7) != 0));
    endtask

    // which entries a scan of line ny would display
    task automatic model_scan(input int ny);
        int cnt;
        cnt      = 0;
        pend_ovf = 1'b0;
        for (int s = 0; s < NS; s++) begin
            n_v[s] = 1'b0; n_x[s] = 0; n_row[s] = 0;
        end
        for (int i = 0; i < NP; i++) begin
            if (m_v[i] && ny >= m_y[i] && ny - m_y[i] < 15) begin
                if (cnt < NS) begin
                    n_v[cnt] = 1'b1; n_x[cnt] = m_x[i]; n_row[cnt] = ny - m_y[i];
                    cnt++;
                end else begin
                    pend_ovf = 1'b1;
                end
            end
        end
    endtask

    // new_line in the current cycle, full scan with pixel probes against the old set
    task automatic run_scan(input int ny);
        model_scan(ny);
        new_line = 1'b1;
        next_y   = 10'(ny);
        rand_probe("scan0");
        new_line = 1'b0;
        for (int k = 1; k <= NP + 1; k++) begin
            chk("busy_hi", 32'(scan_busy), 32'd1);
            rand_probe("during_scan");
        end
        chk("busy_lo", 32'(scan_busy), 32'd0);
        for (int s = 0; s < NS; s++) begin
            a_v[s] = n_v[s]; a_x[s] = n_x[s]; a_row[s] = n_row[s];
        end
        if (pend_ovf) m_ovf = 1'b1;
        chk("overflow", 32'(line_overflow), 32'(m_ovf));
    endtask

    task automatic clear_model();
        for (int i = 0; i < NP; i++) begin
            m_v[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
        end
        for (int s = 0; s < NS; s++) begin
            a_v[s] = 1'b0; a_x[s] = 0; a_row[s] = 0;
        end
        m_ovf = 1'b0;
    endtask

    initial begin
        int base;
        int ny;
        int y;
        reset = 1'b1; new_line = 1'b0; next_y = 10'd0; beam_x = 11'd0; draw = 1'b0;
        wr_en = 1'b0; wr_idx = 4'd0; wr_valid = 1'b0; wr_x = 9'd0; wr_y = 10'd0;
        clear_model();
        tick(); tick();
        chk("rst_transp", 32'(platform_transparencies), 32'd1);
        chk("rst_color", 32'(platform_colors), 32'd0);
        chk("rst_busy", 32'(scan_busy), 32'd0);
        chk("rst_ovf", 32'(line_overflow), 32'd0);
        reset = 1'b0;
        tick();

        // single platform, full column sweep incl. both just-outside columns
        wr(0, 1'b1, 100, 200);
        run_scan(205);
        for (int bx = 438; bx <= 500; bx++) probe("sweep", bx, 1'b1);

        // vertical boundaries and clipping / draw gating
        wr(1, 1'b1, 330, 200);
        run_scan(214);
        probe("y214_l", 441, 1'b1);
        probe("y214_r", 497, 1'b1);
        probe("clip_in", 681, 1'b1);
        probe("clip_682", 682, 1'b1);
        probe("clip_700", 700, 1'b1);
        probe("x300", 300, 1'b1);
        probe("nodraw", 450, 1'b0);
        run_scan(215);
        probe("y215", 441, 1'b1);
        run_scan(199);
        probe("y199", 441, 1'b1);

        // six hits on one line: four shown, overflow sticky
        for (int i = 0; i < 6; i++) wr(i, 1'b1, i * 60, 50);
        run_scan(50);
        for (int i = 0; i < 6; i++) probe("ovf_slot", 341 + i * 60 + 10, 1'b1);

        // aborted scan: restart at scan cycle 5, commit reflects second line
        model_scan(55);
        new_line = 1'b1; next_y = 10'd55;
        rand_probe("abort0");
        new_line = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("abort_busy", 32'(scan_busy), 32'd1);
            rand_probe("abort_old");
        end
        run_scan(700);
        for (int i = 0; i < 4; i++) probe("abort_new", 341 + i * 60 + 10, 1'b1);

        // randomized tables, round 0 exercises y near 1023 against a small next_y
        for (int r = 0; r < 8; r++) begin
            base = (r == 0) ? 1010 : int'($urandom_range(0, 1023));
            for (int i = 0; i < NP; i++) begin
                y = base + int'($urandom_range(0, 30)) - 15;
                if (y < 0) y = 0;
                if (y > 1023) y = 1023;
                wr(i, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 511)), y);
            end
            ny = (r == 0) ? int'($urandom_range(0, 3)) : base + int'($urandom_range(0, 10)) - 5;
            if (ny < 0) ny = 0;
            if (ny > 1023) ny = 1023;
            run_scan(ny);
            for (int p = 0; p < 30; p++) rand_probe("rand");
        end

        // asynchronous reset in the middle of a scan
        wr(0, 1'b1, 100, 200);
        run_scan(205);
        new_line = 1'b1; next_y = 10'd205; beam_x = 11'd460; draw = 1'b1;
        tick();
        new_line = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("arst_transp", 32'(platform_transparencies), 32'd1);
        chk("arst_color", 32'(platform_colors), 32'd0);
        chk("arst_busy", 32'(scan_busy), 32'd0);
        chk("arst_ovf", 32'(line_overflow), 32'd0);
        clear_model();
        tick();
        reset = 1'b0;
        tick();
        run_scan(205);
        probe("post_rst", 460, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/platform_line_scheduler.md
Name: platform_line_scheduler

Overview:
Per-scanline platform scheduler feeding the pixel painter's platform_colors / platform_transparencies inputs.
- Holds a table of N platforms.
- During horizontal blanking, scans the table for platforms that intersect the next line and loads up to SLOTS of them into a shadow slot set.
- On scan completion, swaps the shadow set into the active set.
- During active video, resolves beam_x against the active slots and outputs one registered platform colour plus a transparency flag.

Parameters:
N_PLATFORMS, 16, table depth (power of 2)
SLOTS, 4, max platforms displayable per scanline
PLAT_W, 57, platform width in pixels
PLAT_H, 15, platform height in lines
FIELD_X0, 341, first playfield column (absolute beam_x)
FIELD_X1, 682, first column past playfield

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
new_line  in  1  one-cycle pulse at start of hblank
next_y  in  10  line number about to be displayed; sampled with new_line
beam_x  in  11  current beam column
draw  in  1  active-video qualifier
wr_en  in  1  table write strobe
wr_idx  in  $clog2(N_PLATFORMS)  entry to write
wr_valid  in  1  entry enable
wr_x  in  9  platform left edge, relative to FIELD_X0
wr_y  in  10  platform top line
platform_colors  out  [2:0][3:0]  {R,G,B} of the winning platform
platform_transparencies  out  1  1 = no platform at this pixel
scan_busy  out  1  scan in progress
line_overflow  out  1  sticky; more than SLOTS hits on some line

Behaviour:
- Reset (async, active-high), all cleared immediately:
  - table valid bits = 0; active and shadow slots invalid; FSM = IDLE
  - platform_transparencies = 1, platform_colors = 0, scan_busy = 0, line_overflow = 0
- FSM states IDLE, SCAN, COMMIT:
  - IDLE: on new_line, latch next_y, clear shadow slots and hit count, idx = 0, go to SCAN.
  - SCAN: one entry per cycle, idx 0..N_PLATFORMS-1, lowest index first.
    - Entry is a hit when valid && next_y >= y && next_y - y < PLAT_H. Compute in 11-bit unsigned; no wrap for y near 1023.
    - A hit with count < SLOTS fills shadow slot[count] and increments count.
    - A hit with count == SLOTS sets line_overflow and the entry is dropped.
    - After idx = N_PLATFORMS-1, go to COMMIT.
  - COMMIT: active <= shadow in one cycle, then go to IDLE.
  - new_line during SCAN or COMMIT aborts: relatch next_y, restart at idx 0, active set unchanged.
- Scan timing: new_line at cycle t means entries are evaluated in cycles t+1..t+N, COMMIT is at t+N+1, and the active set is valid from t+N+2.
  - scan_busy is high for cycles t+1..t+N+1.
- Table writes:
  - Take effect the next cycle.
  - If a write and a scan read hit the same entry in the same cycle, the scan uses the old value.
  - Writes never stall.
- Pixel resolution, registered, latency 1: outputs at cycle c+1 reflect beam_x and draw at cycle c. The top level delays beam_x into the painter by one cycle.
  - rel = beam_x - FIELD_X0.
  - Hit when draw, FIELD_X0 <= beam_x < FIELD_X1, slot valid, and x <= rel < x + PLAT_W (10-bit compare).
  - The lowest-numbered hitting slot wins.
  - Hit: colours = PLAT_RGB, transparency = 0. Otherwise colours = 0, transparency = 1.
  - Platforms extending past FIELD_X1 are clipped.
- line_overflow clears only on reset.

Optional Feature:
PLATFORM_EDGE_SHADE_EN
- When defined: pixels on the first or last column of a platform, or on its first or last line (next_y - y == 0 or PLAT_H-1, stored per slot at scan), output PLAT_EDGE_RGB.
- When undefined: every platform pixel is PLAT_RGB, and no row-offset storage is synthesised.

Decomposition:
- Package platform_pkg:
  - rgb_t (packed [2:0][3:0])
  - platform_t struct {valid, x[8:0], y[9:0]}
  - slot_t struct {valid, x[8:0], edge_row}
  - PLAT_RGB = {4'h4, 4'hB, 4'h2}; PLAT_EDGE_RGB = {4'h1, 4'h6, 4'h0}
  - FSM state enum
- One combinational sub-module, platform_hit_test: takes a slot and rel, returns hit and edge. Instanced SLOTS times.

Test Plan:
- Entry 0 at x=100, y=200; new_line with next_y=205. After 18 cycles, beam_x=441..497 gives transparency 0 and colour 4,B,2 (one cycle later); beam_x 440 and 498 give transparency 1.
- Six entries all at y=50; scan with next_y=50. Only indices 0..3 are shown and line_overflow = 1.
- Entry at y=200: next_y=214 hits; next_y=215 and next_y=199 miss.
- beam_x=300 or 700 with a slot hit → transparency 1. draw=0 → transparency 1.
- new_line at scan cycle 5, then again: scan_busy stays high, the active set is unchanged until the second scan commits, and the commit reflects the second next_y.
- Assert reset mid-SCAN: all outputs are at reset values within the same cycle, and the table is invalid.
